// File: rtl/simd_mc_pkg.sv
// Shared types and defaults for the memory-controller feeder of the SIMD core.
// Instruction codes must stay in step with simd_top_level's decoder.
package simd_mc_pkg;

  localparam int MC_DATA_W  = 128;
  localparam int MC_DEPTH   = 64;
  localparam int MC_ADDR_W  = 6;
  localparam int MC_INSTR_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [MC_INSTR_W-1:0] INSTR_ADD  = 3'b000;
  localparam logic [MC_INSTR_W-1:0] INSTR_SUB  = 3'b001;
  localparam logic [MC_INSTR_W-1:0] INSTR_MUL  = 3'b010;
  localparam logic [MC_INSTR_W-1:0] INSTR_AND  = 3'b011;
  localparam logic [MC_INSTR_W-1:0] INSTR_OR   = 3'b100;
  localparam logic [MC_INSTR_W-1:0] INSTR_XOR  = 3'b101;

endpackage

// File: rtl/simd_mc_opbuf.sv
// Operand-pair register file: one registered write port, one combinational read of A and B.
// Storage has no reset; contents are undefined until written.
module simd_mc_opbuf
  import simd_mc_pkg::*;
#(
  parameter int DATA_W = MC_DATA_W,
  parameter int DEPTH  = MC_DEPTH,
  parameter int ADDR_W = MC_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_a[waddr] <= wdata_a;
      mem_b[waddr] <= wdata_b;
    end
  end

  assign rdata_a = mem_a[raddr];
  assign rdata_b = mem_b[raddr];

endmodule

// File: rtl/simd_mc_feeder.sv
// Streams buffered operand pairs to the SIMD core, one per accepted cycle; first pair one cycle after start.
// core_ready low holds every output stable; writes while busy are dropped and flagged by wr_reject.
module simd_mc_feeder
  import simd_mc_pkg::*;
#(
  parameter int DATA_W  = MC_DATA_W,
  parameter int DEPTH   = MC_DEPTH,
  parameter int ADDR_W  = MC_ADDR_W,
  parameter int INSTR_W = MC_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data_a,
  input  logic [DATA_W-1:0]  wr_data_b,
  output logic               wr_reject,
  input  logic               start,
  input  logic [INSTR_W-1:0] start_instruction,
  input  logic [ADDR_W-1:0]  start_size,
  input  logic               core_ready,
  output logic               busy,
  output logic               done,
  output logic               valid_data,
  output logic               valid_instruction,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  data_size,
  output logic [DATA_W-1:0]  mc_data_in_opa,
  output logic [DATA_W-1:0]  mc_data_in_opb
);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   ptr, ptr_inc, n_pairs;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_a, rd_b, nxt_a, nxt_b;
  logic              load_first, advance, finish, wr_ok, fwd, last;

  assign wr_ok   = wr_en && !busy;
  assign ptr_inc = ptr + 1'b1;
  assign last    = (ptr == n_pairs - 1'b1);
  assign rd_addr = load_first ? '0 : ptr_inc[ADDR_W-1:0];

  simd_mc_opbuf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_opbuf (
    .clk     (clk),
    .we      (wr_ok),
    .waddr   (wr_addr),
    .wdata_a (wr_data_a),
    .wdata_b (wr_data_b),
    .raddr   (rd_addr),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // A write landing on the same edge as the first read must be seen by that read.
  assign fwd   = wr_ok && (wr_addr == rd_addr);
  assign nxt_a = fwd ? wr_data_a : rd_a;
  assign nxt_b = fwd ? wr_data_b : rd_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = STREAM;
          load_first = 1'b1;
        end
      end
      STREAM: begin
        if (core_ready) begin
          if (last) begin
            state_nxt = DONE;
            finish    = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr               <= '0;
      n_pairs           <= '0;
      wr_reject         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      valid_data        <= 1'b0;
      valid_instruction <= 1'b0;
      instruction       <= '0;
      data_size         <= '0;
      mc_data_in_opa    <= '0;
      mc_data_in_opb    <= '0;
    end else begin
      wr_reject <= wr_en && busy;
      if (load_first) begin
        ptr               <= '0;
        // A size of zero means a full buffer, hence the extra pointer bit.
        n_pairs           <= (start_size == '0) ? (ADDR_W+1)'(DEPTH) : {1'b0, start_size};
        instruction       <= start_instruction;
        data_size         <= start_size;
        busy              <= 1'b1;
        valid_data        <= 1'b1;
        valid_instruction <= 1'b1;
        mc_data_in_opa    <= nxt_a;
        mc_data_in_opb    <= nxt_b;
      end else if (advance) begin
        ptr            <= ptr_inc;
        mc_data_in_opa <= nxt_a;
        mc_data_in_opb <= nxt_b;
      end else if (finish) begin
        valid_data        <= 1'b0;
        valid_instruction <= 1'b0;
        done              <= 1'b1;
      end else if (state == DONE) begin
        done <= 1'b0;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simd_mc_feeder.sv
// Randomized and directed checks of simd_mc_feeder against an array model of the operand buffer.
module tb_simd_mc_feeder;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wr_en = 1'b0;
  logic [5:0]   wr_addr = '0;
  logic [127:0] wr_data_a = '0;
  logic [127:0] wr_data_b = '0;
  logic         wr_reject;
  logic         start = 1'b0;
  logic [2:0]   start_instruction = '0;
  logic [5:0]   start_size = '0;
  logic         core_ready = 1'b0;
  logic         busy, done, valid_data, valid_instruction;
  logic [2:0]   instruction;
  logic [5:0]   data_size;
  logic [127:0] mc_data_in_opa, mc_data_in_opb;

  logic [127:0] ma [64];
  logic [127:0] mb [64];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  simd_mc_feeder dut (
    .clk               (clk),
    .reset             (reset),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data_a         (wr_data_a),
    .wr_data_b         (wr_data_b),
    .wr_reject         (wr_reject),
    .start             (start),
    .start_instruction (start_instruction),
    .start_size        (start_size),
    .core_ready        (core_ready),
    .busy              (busy),
    .done              (done),
    .valid_data        (valid_data),
    .valid_instruction (valid_instruction),
    .instruction       (instruction),
    .data_size         (data_size),
    .mc_data_in_opa    (mc_data_in_opa),
    .mc_data_in_opb    (mc_data_in_opb)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int addr, input logic [127:0] a, input logic [127:0] b);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 6'(addr); wr_data_a = a; wr_data_b = b;
    @(negedge clk);
    wr_en = 1'b0;
    ma[addr] = a;
    mb[addr] = b;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid_data"}, valid_data, 1'b0);
    chk({tag, "_valid_instr"}, valid_instruction, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_instr"}, instruction, 3'b000);
    chk({tag, "_size"}, data_size, 6'd0);
    chk({tag, "_opa"}, mc_data_in_opa, 128'd0);
    chk({tag, "_opb"}, mc_data_in_opb, 128'd0);
    chk({tag, "_wr_reject"}, wr_reject, 1'b0);
  endtask

  // poke: 0 none, 1 write entry0 during stream, 2 restart during stream, 3 write entry0 with start
  task automatic run_stream(input logic [2:0] ins, input logic [5:0] sz, input int stall_first,
                            input bit rnd, input int poke);
    int n, idx, cyc;
    bit rdy;
    logic [127:0] nw;
    n = (sz == 6'd0) ? 64 : int'(sz);
    @(negedge clk);
    start = 1'b1; start_instruction = ins; start_size = sz;
    if (poke == 3) begin
      nw = {$urandom, $urandom, $urandom, $urandom};
      wr_en = 1'b1; wr_addr = 6'd0; wr_data_a = nw; wr_data_b = ~nw;
      ma[0] = nw;
      mb[0] = ~nw;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 4000) begin
      chk("stream_valid_data", valid_data, 1'b1);
      chk("stream_valid_instr", valid_instruction, 1'b1);
      chk("stream_busy", busy, 1'b1);
      chk("stream_done", done, 1'b0);
      chk("stream_instr", instruction, ins);
      chk("stream_size", data_size, sz);
      chk("stream_opa", mc_data_in_opa, ma[idx]);
      chk("stream_opb", mc_data_in_opb, mb[idx]);
      chk("stream_wr_reject", wr_reject, (poke == 1 && cyc == 1));
      start = (poke == 2 && cyc == 0);
      start_instruction = (poke == 2) ? 3'b101 : ins;
      start_size = (poke == 2) ? 6'd5 : sz;
      wr_en = (poke == 1 && cyc == 0);
      wr_addr = 6'd0; wr_data_a = 128'd99999999; wr_data_b = 128'd99999999;
      rdy = (cyc < stall_first) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      core_ready = rdy;
      if (rdy) idx++;
      cyc++;
      @(negedge clk);
    end
    if (idx < n) chk("stream_timeout", 128'(idx), 128'(n));
    start = 1'b0; wr_en = 1'b0;
    core_ready = 1'($urandom_range(0, 1));
    chk("done_pulse", done, 1'b1);
    chk("done_valid_data", valid_data, 1'b0);
    chk("done_valid_instr", valid_instruction, 1'b0);
    chk("done_busy", busy, 1'b1);
    @(negedge clk);
    chk("after_done", done, 1'b0);
    chk("after_busy", busy, 1'b0);
    chk("after_valid", valid_data, 1'b0);
  endtask

  initial begin
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    load(0, 128'h11111111_22222222_55555555_66666666, 128'h11111111_22222222_33333333_44444444);
    load(1, 128'h22222222_11111111_55555555_66666666, 128'h22222222_11111111_33333333_44444444);
    run_stream(3'b000, 6'd2, 0, 1'b0, 0);
    run_stream(3'b000, 6'd2, 2, 1'b0, 0);

    for (int k = 0; k < 64; k++) load(k, 128'(k), 128'(k));
    run_stream(3'b000, 6'd0, 0, 1'b0, 0);

    run_stream(3'b000, 6'd3, 1, 1'b0, 1);
    run_stream(3'b000, 6'd1, 0, 1'b0, 0);
    run_stream(3'b000, 6'd4, 0, 1'b0, 2);

    // Abandon a 6-pair stream while the second pair is on the outputs.
    @(negedge clk);
    start = 1'b1; start_instruction = 3'b001; start_size = 6'd6; core_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_opa", mc_data_in_opa, ma[1]);
    reset = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (2) @(negedge clk);
    chk("midreset_no_done", done, 1'b0);
    reset = 1'b1;
    run_stream(3'b010, 6'd1, 0, 1'b0, 0);

    run_stream(3'b011, 6'd2, 0, 1'b0, 3);

    for (int it = 0; it < 8; it++) begin
      int cnt;
      cnt = $urandom_range(1, 8);
      for (int j = 0; j < cnt; j++)
        load($urandom_range(0, 63), {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom});
      run_stream(3'($urandom), 6'($urandom), $urandom_range(0, 2), 1'b1, (it % 4 == 3) ? 3 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
